// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch unit and the control FSM: stage and fetch-state
// encodings, opcode field position, opcode constants and the default reset PC.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IFETCH    = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4
    } stage_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    localparam logic [5:0] OP_ADD = 6'h00;
    localparam logic [5:0] OP_SUB = 6'h01;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch.sv
// PC owner with one outstanding imem read; >=2 cycles/instr, instr held stable while instr_ready=0.
// Defining IFETCH_STALL_CNT_EN adds a saturating stall_cnt output.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int                PC_INC   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [5:0]        instr_opcode,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFETCH_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic              valid_q;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              pend_q;
    logic [ADDR_W-1:0] pend_pc_q;

    logic [ADDR_W-1:0] redir_tgt;
    logic [ADDR_W-1:0] redir_sel;
    logic [ADDR_W-1:0] pc_seq;

    assign redir_tgt = redirect_pc & ~ADDR_W'(3);
    // A same-cycle redirect is newer than anything already pending.
    assign redir_sel = redirect_valid ? redir_tgt : pend_pc_q;
    assign pc_seq    = pc_q + ADDR_W'(PC_INC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            pend_q     <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (redirect_valid) begin
                        pc_q <= redir_tgt;
                    end else if (run) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                    end
                end
                S_REQ: begin
                    if (imem_rvalid) begin
                        if (redirect_valid || pend_q) begin
                            pc_q   <= redir_sel;
                            addr_q <= redir_sel;
                            pend_q <= 1'b0;
                        end else begin
                            instr_q    <= imem_rdata;
                            instr_pc_q <= pc_q;
                            valid_q    <= 1'b1;
                            req_q      <= 1'b0;
                            state_q    <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        // The in-flight read must finish at its original address.
                        pend_q    <= 1'b1;
                        pend_pc_q <= redir_tgt;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        valid_q <= 1'b0;
                        pc_q    <= redir_tgt;
                        addr_q  <= redir_tgt;
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
                    end else if (instr_ready) begin
                        valid_q <= 1'b0;
                        pc_q    <= pc_seq;
                        if (run) begin
                            addr_q  <= pc_seq;
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = addr_q;
    assign instr_valid  = valid_q;
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign instr_opcode = instr_q[OPCODE_MSB:OPCODE_LSB];

`ifdef IFETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if ((stall_cnt_q != 32'hFFFF_FFFF) &&
                     (((state_q == S_REQ) && !imem_rvalid) ||
                      ((state_q == S_HOLD) && !instr_ready))) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: latency-programmable memory model plus an in-order scoreboard of (pc, instr).
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [5:0]  instr_opcode;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef IFETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_opcode   (instr_opcode),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFETCH_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          mem_lat = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_req_addr = '0;
    int          cyc = 0;
    int          hs_n = 0;
    int          hs_prev = 0;
    int          hs_last = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:2], a[25:0] ^ 26'h20};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_t e;
        e.pc  = a;
        e.ins = mem_word(a);
        sb.push_back(e);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!imem_req && n < 50) begin
            step();
            n++;
        end
        chk(tag, imem_req, 1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!instr_valid && n < 50) begin
            step();
            n++;
        end
        chk(tag, instr_valid, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((imem_req || instr_valid) && n < 50) begin
            step();
            n++;
        end
        chk(tag, {imem_req, instr_valid}, 0);
    endtask

    task automatic set_pc(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        step();
        redirect_valid = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: a request first visible at a negedge is answered after mem_lat cycles.
    always @(negedge clk) begin
        if (!imem_req) begin
            mem_cnt     = 0;
            imem_rvalid = 1'b0;
        end else begin
            if (imem_rvalid || mem_cnt == 0) begin
                mem_cnt      = 1;
                mem_req_addr = imem_addr;
                chk("addr_align", imem_addr[1:0], 2'b00);
            end else begin
                mem_cnt++;
                chk("addr_stable", imem_addr, mem_req_addr);
            end
            imem_rvalid = (mem_cnt == mem_lat);
        end
        imem_rdata = imem_rvalid ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end

    // Decode side: each valid&ready cycle consumes the oldest expected instruction.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            chk("sb_avail", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_pc", instr_pc, e.pc);
                chk("sb_instr", instr, e.ins);
                chk("sb_opcode", instr_opcode, e.ins[31:26]);
            end
            hs_prev = hs_last;
            hs_last = cyc;
            hs_n++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", n_chk);
        $fatal(1);
    end

    initial begin
        int          n;
        int          hs0;
        logic [31:0] held;

        rst_n          = 1'b0;
        run            = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        #2;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Basic fetch with 1-cycle memory, then sequential PC and throughput.
        mem_lat = 1;
        push_exp(32'h0);
        push_exp(32'h4);
        run = 1'b1;
        wait_req("t1_req0");
        chk("t1_addr0", imem_addr, 32'h0);
        wait_valid("t1_valid0");
        chk("t1_instr0", instr, 32'h20);
        chk("t1_pc0", instr_pc, 32'h0);
        chk("t1_op0", instr_opcode, 6'h0);
        wait_req("t1_req1");
        chk("t1_addr1", imem_addr, 32'h4);
        run = 1'b0;
        wait_valid("t1_valid1");
        wait_idle("t1_idle");
        chk("t1_thruput", hs_last - hs_prev, 2);

        // 3-cycle memory latency: request held, exactly one instruction.
        mem_lat = 3;
        set_pc(32'h8);
        push_exp(32'h8);
        hs0 = hs_n;
        run = 1'b1;
        wait_req("t2_req");
        chk("t2_addr", imem_addr, 32'h8);
        run = 1'b0;
        n = 0;
        while (!instr_valid && n < 20) begin
            chk("t2_req_held", imem_req, 1);
            step();
            n++;
        end
        chk("t2_latency", n, 3);
        wait_idle("t2_idle");
        chk("t2_one_instr", hs_n - hs0, 1);

        // Redirects while a read is outstanding: data dropped, last target wins, low bits masked.
        set_pc(32'h0);
        run = 1'b1;
        wait_req("t3_req");
        chk("t3_addr0", imem_addr, 32'h0);
        run            = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        chk("t3_novalid_a", instr_valid, 0);
        redirect_pc = 32'h103;
        step();
        chk("t3_novalid_b", instr_valid, 0);
        redirect_valid = 1'b0;
        push_exp(32'h100);
        step();
        chk("t3_novalid_c", instr_valid, 0);
        chk("t3_req_redir", imem_req, 1);
        chk("t3_addr_redir", imem_addr, 32'h100);
        wait_valid("t3_valid");
        wait_idle("t3_idle");

        // Redirect in the same cycle as read data.
        mem_lat = 1;
        set_pc(32'h700);
        run = 1'b1;
        wait_req("t3b_req");
        run            = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h41;
        step();
        redirect_valid = 1'b0;
        push_exp(32'h40);
        chk("t3b_novalid", instr_valid, 0);
        chk("t3b_addr", imem_addr, 32'h40);
        wait_valid("t3b_valid");
        wait_idle("t3b_idle");

        // Decode stalls 5 cycles, then redirect together with ready.
        set_pc(32'h600);
        push_exp(32'h600);
        instr_ready = 1'b0;
        run         = 1'b1;
        wait_req("t4_req");
        wait_valid("t4_valid");
        held = mem_word(32'h600);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_valid", instr_valid, 1);
            chk("t4_hold_instr", instr, held);
        end
        run            = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        push_exp(32'h300);
        step();
        redirect_valid = 1'b0;
        chk("t4_drop_valid", instr_valid, 0);
        chk("t4_req", imem_req, 1);
        chk("t4_addr", imem_addr, 32'h300);
        wait_valid("t4_valid2");
        wait_idle("t4_idle");

        // PC wrap at the top of the address space.
        set_pc(32'hFFFF_FFFC);
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0);
        run = 1'b1;
        wait_req("t5_req0");
        chk("t5_addr0", imem_addr, 32'hFFFF_FFFC);
        wait_valid("t5_valid0");
        wait_req("t5_req1");
        chk("t5_addr_wrap", imem_addr, 32'h0);
        run = 1'b0;
        wait_valid("t5_valid1");
        wait_idle("t5_idle");

        // Asynchronous reset while a request is outstanding.
        mem_lat = 3;
        set_pc(32'h500);
        run = 1'b1;
        wait_req("t6_req");
        chk("t6_addr", imem_addr, 32'h500);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_req", imem_req, 0);
        chk("t6_async_valid", instr_valid, 0);
        step();
        push_exp(32'h0);
        rst_n = 1'b1;
        wait_req("t6_req_after");
        chk("t6_addr_reset_pc", imem_addr, 32'h0);
        run = 1'b0;
        wait_valid("t6_valid");
        wait_idle("t6_idle");

        repeat (3) step();
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
